prescaled_mod_counter: RTL and testbench

- Parametrised successor to the fixed-width free-running register counter.
- Counts over a configurable modulus 0..MODULUS-1, either up or down, advancing once per PRESCALE enabled cycles.
- Supports synchronous clear and load, and a wrap or saturate mode.
- Exposes the count, a terminal-count pulse and a prescaler tick as outputs; used as a timebase/event counter by peripheral blocks.

---
 rtl/prescaled_mod_counter_pkg.sv | 17 +
 rtl/prescaled_mod_counter_prescaler.sv | 38 +++
 rtl/prescaled_mod_counter.sv | 116 +++++++++++
 tb/tb_prescaled_mod_counter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prescaled_mod_counter_pkg.sv
// Shared types and helpers for the prescaled modulus counter and its prescaler.
package prescaled_mod_counter_pkg;

    typedef enum logic {
        MODE_WRAP     = 1'b0,
        MODE_SATURATE = 1'b1
    } mode_e;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Prescaler width; PRESCALE == 1 still needs a one-bit register.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/prescaled_mod_counter_prescaler.sv
// Enable-gated prescaler: asserts step on every PRESCALE-th enabled cycle.
module counter_prescaler
    import prescaled_mod_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic step
);

    localparam int              PW   = clog2_min1(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;

    always_comb begin
        step    = enable && (count_q == LAST);
        count_d = count_q;
        if (restart) begin
            count_d = '0;
        end else if (enable) begin
            count_d = step ? '0 : count_q + PW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/prescaled_mod_counter.sv
// Up/down modulus counter with prescaler, clear/load, wrap or saturate,
// and registered terminal-count and tick pulses.
module prescaled_mod_counter
    import prescaled_mod_counter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MODULUS     = 100,
    parameter int PRESCALE    = 1,
    parameter int RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             saturate,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] get_count_ret,
    output logic             get_tc_ret,
    output logic             get_tick_ret
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("prescaled_mod_counter: WIDTH must be >= 1");
        end
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("prescaled_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("prescaled_mod_counter: PRESCALE must be >= 1");
        end
        if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset_value
            $error("prescaled_mod_counter: RESET_VALUE must be < MODULUS");
        end
    endgenerate

    // One extra bit so MODULUS == 2**WIDTH compares and increments cleanly.
    localparam logic [WIDTH:0] LIMIT = (WIDTH + 1)'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             tick_q, tick_d;
    logic             restart;
    logic             step;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   count_inc;
    mode_e            mode;

    assign restart   = clear | load;
    assign count_ext = {1'b0, count_q};
    assign load_ext  = {1'b0, load_value};
    assign count_inc = count_ext + (WIDTH + 1)'(1);
    assign mode      = mode_e'(saturate);

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .restart (restart),
        .step    (step)
    );

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        tick_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_ext > LIMIT) ? LIMIT[WIDTH-1:0] : load_value;
        end else if (step) begin
            tick_d = 1'b1;
            if (up == DIR_UP) begin
                if (count_ext == LIMIT) begin
                    tc_d = 1'b1;
                    if (mode == MODE_WRAP) begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_inc[WIDTH-1:0];
                end
            end else begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
                    if (mode == MODE_WRAP) begin
                        count_d = LIMIT[WIDTH-1:0];
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= WIDTH'(RESET_VALUE);
            tc_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            tick_q  <= tick_d;
        end
    end

    assign get_count_ret = count_q;
    assign get_tc_ret    = tc_q;
    assign get_tick_ret  = tick_q;

endmodule

// File: tb/tb_prescaled_mod_counter.sv
// Four counter configurations driven in parallel and checked against an arithmetic model.
module tb_prescaled_mod_counter;

    localparam int N = 4;
    localparam int M_MOD [N] = '{10, 10, 100, 16};
    localparam int P_PRE [N] = '{1, 3, 4, 1};
    localparam int R_VAL [N] = '{5, 0, 0, 0};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       up = 1'b1;
    logic       saturate = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;

    logic [7:0] cnt0, cnt1, cnt2;
    logic [3:0] cnt3;
    logic [N-1:0] tc_o, tick_o;
    logic [7:0] obs_cnt [N];

    int m_cnt [N];
    int m_pre [N];
    bit m_tc [N];
    bit m_tick [N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    always_comb begin
        obs_cnt[0] = cnt0;
        obs_cnt[1] = cnt1;
        obs_cnt[2] = cnt2;
        obs_cnt[3] = {4'd0, cnt3};
    end

    prescaled_mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .RESET_VALUE(5)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
        .clear(clear), .load(load), .load_value(load_value),
        .get_count_ret(cnt0), .get_tc_ret(tc_o[0]), .get_tick_ret(tick_o[0]));

    prescaled_mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(3), .RESET_VALUE(0)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
        .clear(clear), .load(load), .load_value(load_value),
        .get_count_ret(cnt1), .get_tc_ret(tc_o[1]), .get_tick_ret(tick_o[1]));

    prescaled_mod_counter #(.WIDTH(8), .MODULUS(100), .PRESCALE(4), .RESET_VALUE(0)) dut2 (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
        .clear(clear), .load(load), .load_value(load_value),
        .get_count_ret(cnt2), .get_tc_ret(tc_o[2]), .get_tick_ret(tick_o[2]));

    prescaled_mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .RESET_VALUE(0)) dut3 (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
        .clear(clear), .load(load), .load_value(load_value[3:0]),
        .get_count_ret(cnt3), .get_tc_ret(tc_o[3]), .get_tick_ret(tick_o[3]));

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = R_VAL[i];
            m_pre[i]  = 0;
            m_tc[i]   = 1'b0;
            m_tick[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit en, input bit u, input bit sat,
                              input bit clr, input bit ld, input int lv);
        for (int i = 0; i < N; i++) begin
            int lim = M_MOD[i] - 1;
            int v   = (i == 3) ? (lv % 16) : (lv % 256);
            m_tc[i]   = 1'b0;
            m_tick[i] = 1'b0;
            if (clr) begin
                m_cnt[i] = 0;
                m_pre[i] = 0;
            end else if (ld) begin
                m_cnt[i] = (v > lim) ? lim : v;
                m_pre[i] = 0;
            end else if (en) begin
                if (m_pre[i] == P_PRE[i] - 1) begin
                    m_pre[i]  = 0;
                    m_tick[i] = 1'b1;
                    if (u) begin
                        if (m_cnt[i] == lim) begin
                            m_tc[i] = 1'b1;
                            if (!sat) m_cnt[i] = 0;
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end else begin
                        if (m_cnt[i] == 0) begin
                            m_tc[i] = 1'b1;
                            if (!sat) m_cnt[i] = lim;
                        end else begin
                            m_cnt[i] = m_cnt[i] - 1;
                        end
                    end
                end else begin
                    m_pre[i] = m_pre[i] + 1;
                end
            end
        end
    endtask

    // Drive one edge's inputs, advance the model across the edge, settle past it.
    task automatic step_cycle(input bit en, input bit u, input bit sat,
                              input bit clr, input bit ld, input int lv);
        enable     = en;
        up         = u;
        saturate   = sat;
        clear      = clr;
        load       = ld;
        load_value = 8'(lv);
        @(posedge clock);
        if (reset) model_reset();
        else model_edge(en, u, sat, clr, ld, lv);
        #1;
        cyc++;
        $display("cyc %0d rst=%0b en=%0b up=%0b sat=%0b clr=%0b ld=%0b lv=%0d -> cnt=%0d/%0d/%0d/%0d tc=%b tick=%b",
                 cyc, reset, en, u, sat, clr, ld, lv, cnt0, cnt1, cnt2, cnt3, tc_o, tick_o);
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            checks += 3;
            if (obs_cnt[i] !== 8'(R_VAL[i])) begin
                errors++;
                $display("FAIL reset_init dut%0d count=%0d expected %0d", i, obs_cnt[i], R_VAL[i]);
            end
            if (tc_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_init dut%0d tc=%b expected 0", i, tc_o[i]);
            end
            if (tick_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_init dut%0d tick=%b expected 0", i, tick_o[i]);
            end
        end
        repeat (7) step_cycle(1, 1, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < N; i++) begin
            checks += 3;
            if (obs_cnt[i] !== 8'(m_cnt[i])) begin
                errors++;
                $display("FAIL reset_async dut%0d count=%0d expected %0d", i, obs_cnt[i], m_cnt[i]);
            end
            if (tc_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_async dut%0d tc=%b expected 0", i, tc_o[i]);
            end
            if (tick_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_async dut%0d tick=%b expected 0", i, tick_o[i]);
            end
        end
        step_cycle(1, 1, 0, 0, 0, 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step_cycle(1, 1, 0, 0, 0, 0);
            for (int i = 0; i < N; i++) begin
                checks += 3;
                if (obs_cnt[i] !== 8'(m_cnt[i])) begin
                    errors++;
                    $display("FAIL reset_resume dut%0d count=%0d expected %0d", i, obs_cnt[i], m_cnt[i]);
                end
                if (tc_o[i] !== m_tc[i]) begin
                    errors++;
                    $display("FAIL reset_resume dut%0d tc=%b expected %b", i, tc_o[i], m_tc[i]);
                end
                if (tick_o[i] !== m_tick[i]) begin
                    errors++;
                    $display("FAIL reset_resume dut%0d tick=%b expected %b", i, tick_o[i], m_tick[i]);
                end
            end
        end
    endtask

    task automatic test_up_wrap();
        step_cycle(0, 1, 0, 1, 0, 0);
        for (int k = 0; k < 12; k++) begin
            step_cycle(1, 1, 0, 0, 0, 0);
            for (int i = 0; i < N; i++) begin
                checks += 3;
                if (obs_cnt[i] !== 8'(m_cnt[i])) begin
                    errors++;
                    $display("FAIL up_wrap dut%0d count=%0d expected %0d", i, obs_cnt[i], m_cnt[i]);
                end
                if (tc_o[i] !== m_tc[i]) begin
                    errors++;
                    $display("FAIL up_wrap dut%0d tc=%b expected %b", i, tc_o[i], m_tc[i]);
                end
                if (tick_o[i] !== m_tick[i]) begin
                    errors++;
                    $display("FAIL up_wrap dut%0d tick=%b expected %b", i, tick_o[i], m_tick[i]);
                end
            end
            if (k == 9) begin
                checks++;
                if (cnt0 !== 8'd0 || tc_o[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL up_wrap_edge count=%0d tc=%b expected 0 and 1", cnt0, tc_o[0]);
                end
            end
        end
    endtask

    task automatic test_down_saturate();
        step_cycle(0, 0, 1, 0, 1, 2);
        for (int k = 0; k < 15; k++) begin
            step_cycle(1, 0, 1, 0, 0, 0);
            for (int i = 0; i < N; i++) begin
                checks += 3;
                if (obs_cnt[i] !== 8'(m_cnt[i])) begin
                    errors++;
                    $display("FAIL down_sat dut%0d count=%0d expected %0d", i, obs_cnt[i], m_cnt[i]);
                end
                if (tc_o[i] !== m_tc[i]) begin
                    errors++;
                    $display("FAIL down_sat dut%0d tc=%b expected %b", i, tc_o[i], m_tc[i]);
                end
                if (tick_o[i] !== m_tick[i]) begin
                    errors++;
                    $display("FAIL down_sat dut%0d tick=%b expected %b", i, tick_o[i], m_tick[i]);
                end
            end
        end
        checks++;
        if (cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL down_sat_hold count=%0d expected 0", cnt1);
        end
    endtask

    task automatic test_priority();
        step_cycle(1, 1, 0, 1, 1, 7);
        step_cycle(1, 1, 0, 0, 1, 200);
        for (int i = 0; i < N; i++) begin
            checks += 3;
            if (obs_cnt[i] !== 8'(m_cnt[i])) begin
                errors++;
                $display("FAIL priority dut%0d count=%0d expected %0d", i, obs_cnt[i], m_cnt[i]);
            end
            if (tc_o[i] !== m_tc[i]) begin
                errors++;
                $display("FAIL priority dut%0d tc=%b expected %b", i, tc_o[i], m_tc[i]);
            end
            if (tick_o[i] !== m_tick[i]) begin
                errors++;
                $display("FAIL priority dut%0d tick=%b expected %b", i, tick_o[i], m_tick[i]);
            end
        end
        checks++;
        if (cnt2 !== 8'd99) begin
            errors++;
            $display("FAIL priority_clamp count=%0d expected 99", cnt2);
        end
    endtask

    task automatic test_enable_gating();
        bit pattern [6] = '{1, 1, 0, 0, 1, 1};
        step_cycle(0, 1, 0, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step_cycle(pattern[k], 1, 0, 0, 0, 0);
            for (int i = 0; i < N; i++) begin
                checks += 3;
                if (obs_cnt[i] !== 8'(m_cnt[i])) begin
                    errors++;
                    $display("FAIL enable dut%0d count=%0d expected %0d", i, obs_cnt[i], m_cnt[i]);
                end
                if (tc_o[i] !== m_tc[i]) begin
                    errors++;
                    $display("FAIL enable dut%0d tc=%b expected %b", i, tc_o[i], m_tc[i]);
                end
                if (tick_o[i] !== m_tick[i]) begin
                    errors++;
                    $display("FAIL enable dut%0d tick=%b expected %b", i, tick_o[i], m_tick[i]);
                end
            end
        end
        checks++;
        if (cnt2 !== 8'd1 || tick_o[2] !== 1'b1) begin
            errors++;
            $display("FAIL enable_sixth count=%0d tick=%b expected 1 and 1", cnt2, tick_o[2]);
        end
    endtask

    task automatic test_full_range();
        step_cycle(0, 1, 0, 0, 1, 15);
        step_cycle(1, 1, 0, 0, 0, 0);
        checks++;
        if (cnt3 !== 4'd0 || tc_o[3] !== 1'b1) begin
            errors++;
            $display("FAIL full_up_wrap count=%0d tc=%b expected 0 and 1", cnt3, tc_o[3]);
        end
        step_cycle(1, 0, 0, 0, 0, 0);
        checks++;
        if (cnt3 !== 4'd15 || tc_o[3] !== 1'b1) begin
            errors++;
            $display("FAIL full_down_wrap count=%0d tc=%b expected 15 and 1", cnt3, tc_o[3]);
        end
        for (int k = 0; k < 4; k++) begin
            step_cycle(1, k[0], 0, 0, 0, 0);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs_cnt[i] !== 8'(m_cnt[i]) || tc_o[i] !== m_tc[i]) begin
                    errors++;
                    $display("FAIL full_range dut%0d count=%0d tc=%b expected %0d %b",
                             i, obs_cnt[i], tc_o[i], m_cnt[i], m_tc[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                       $urandom_range(0, 19) == 0, int'($urandom_range(0, 255)));
            for (int i = 0; i < N; i++) begin
                checks += 3;
                if (obs_cnt[i] !== 8'(m_cnt[i])) begin
                    errors++;
                    $display("FAIL random dut%0d count=%0d expected %0d", i, obs_cnt[i], m_cnt[i]);
                end
                if (tc_o[i] !== m_tc[i]) begin
                    errors++;
                    $display("FAIL random dut%0d tc=%b expected %b", i, tc_o[i], m_tc[i]);
                end
                if (tick_o[i] !== m_tick[i]) begin
                    errors++;
                    $display("FAIL random dut%0d tick=%b expected %b", i, tick_o[i], m_tick[i]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_up_wrap();
        test_down_saturate();
        test_priority();
        test_enable_gating();
        test_full_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
